deser_pipe: RTL
===============

Name: deser_pipe

Overview:
- Multi-lane successor to the single-bit shift/sync/decode/multiply chain.
- Deserialises LANES serial bit streams into DATA_WIDTH-bit words using a bit counter and a qualifier. There is no divided clock.
- Each word then passes through registered capture, selectable decode and constant-multiply stages.
- Results are buffered in a show-ahead FIFO with a valid/ready output handshake.
- Sits between the serial front end and downstream parallel consumers. Everything runs on fastClk.

Parameters:
- DATA_WIDTH, 4, bits per deserialised word per lane (2..16).
- LANES, 2, number of parallel serial lanes (1..8).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.
- SCALE, 3, multiply constant; range 1..2**DATA_WIDTH-1.

Ports:
- fastClk, input, 1, sole clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-low; clears all state.
- dataIn, input, LANES, one serial bit per lane, MSB first.
- dataInValid, input, 1, qualifies dataIn on this edge.
- mode, input, 2, decode select: 00 pass, 01 bit-reverse, 10 gray-to-binary, 11 invert.
- outReady, input, 1, consumer accepts the FIFO head.
- outValid, output, 1, FIFO not empty.
- dataOut, output, LANES*2*DATA_WIDTH, FIFO head; lane k at bits [k*2W +: 2W].
- fifoCount, output, $clog2(FIFO_DEPTH+1), current occupancy.
- overflow, output, 1, sticky: a word was dropped on a full FIFO.
- parityErr, output, 1, one-cycle pulse on parity failure (see Optional Feature).

Behaviour:
- Reset (reset=0, async):
  - Shift registers, bit counter, stage registers and stage valids are cleared.
  - FIFO pointers, fifoCount, overflow, parityErr and dataOut all go to 0.
- Shift:
  - On an edge with dataInValid=1, each lane performs sr <= {sr[W-2:0], dataIn[k]}.
  - The bit counter increments, wrapping at W-1.
  - With dataInValid=0, shift registers and counter hold.
- Capture (edge N = edge sampling the last bit, counter==W-1 with valid):
  - syncReg <= {sr[W-2:0], dataIn[k]} per lane; mode is latched alongside; syncValid=1 for one cycle.
  - Mode changes at any other edge have no effect on that word.
- Decode (edge N+1): decodeReg <= f(syncReg, latched mode) per lane.
  - Gray-to-binary: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
- Multiply (edge N+2): mulReg <= decodeReg * SCALE, width 2W, unsigned, never truncated.
- FIFO push (edge N+3):
  - The word is written and outValid is visible after edge N+3.
  - Fixed latency: 4 edges from last-bit sampling, with outReady irrelevant while the FIFO is not full.
- Back-to-back words: one word every W valid edges; the stages never stall.
- Pop: occurs on an edge with outValid=1 and outReady=1. dataOut shows the next entry, or holds its last value when the FIFO becomes empty.
- Full:
  - Push with no pop: the word is dropped, overflow is set, fifoCount stays FIFO_DEPTH.
  - Simultaneous push and pop while full: both occur; count unchanged; no overflow.
- Empty: pop is ignored; count never underflows.
- Simultaneous push and pop while empty: push only, count becomes 1.
- Reset mid-word: partially shifted bits are discarded and the counter returns to 0. The first post-reset valid bit is the MSB of a new word.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each lane frame is W+1 valid bits; the final bit is even parity over the W data bits.
  - The counter wraps at W.
  - If any lane fails parity, the whole word is not captured and parityErr pulses for one cycle at the capture edge.
- Undefined: the frame is W bits and parityErr is tied 0.

Test Plan:
- Reset: assert reset=0 mid-traffic -> outValid=0, fifoCount=0, overflow=0, dataOut=0 immediately, without waiting for a clock edge.
- Pass mode (W=4, LANES=2, SCALE=3, mode=00): lane0 bits 1,0,1,1 and lane1 bits 0,0,1,1, outReady=1 -> outValid rises after edge N+3; lane0=0x21, lane1=0x09.
- Decode modes, lane0 word 0x6:
  - mode=01 -> 0x12.
  - mode=10 -> 0x0C.
  - mode=11 -> 0x1B.
  - Changing mode one cycle after capture does not alter the result.
- Backpressure: outReady=0, send 6 words -> fifoCount=4, overflow=1, words 5–6 lost. Then outReady=1 -> words 1–4 drain in order, fifoCount reaches 0, overflow stays 1.
- Gapped input: same bits as the pass-mode test with dataInValid=0 inserted between every bit -> identical output values, latency measured from the last valid bit.
- Reset mid-word: 2 bits shifted, reset pulse, then bits 0,1,1,0 -> exactly one word, lane0=0x12 in pass mode. With DESER_PARITY_EN, a wrong parity bit -> parityErr pulse and no push.

Source files
------------

// File: rtl/deser_pipe.sv
// Multi-lane serial-to-parallel deserialiser feeding decode and constant-multiply stages into a show-ahead output FIFO.
// Optional per-lane even parity frame bit enabled by defining DESER_PARITY_EN.
module deser_pipe #(
   parameter int DATA_WIDTH = 4,
   parameter int LANES      = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int SCALE      = 3
) (
   input  logic                                  fastClk,
   input  logic                                  reset,
   input  logic [LANES-1:0]                      dataIn,
   input  logic                                  dataInValid,
   input  logic [1:0]                            mode,
   input  logic                                  outReady,
   output logic                                  outValid,
   output logic [LANES*2*DATA_WIDTH-1:0]         dataOut,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifoCount,
   output logic                                  overflow,
   output logic                                  parityErr
);
   localparam int W  = DATA_WIDTH;
   localparam int OW = 2 * DATA_WIDTH;
   localparam int DW = LANES * OW;
`ifdef DESER_PARITY_EN
   localparam int FRAME = DATA_WIDTH + 1;
`else
   localparam int FRAME = DATA_WIDTH;
`endif
   localparam int CW = $clog2(FRAME);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);

   logic [W-1:0]   sr       [LANES];
   logic [W-1:0]   sr_nxt   [LANES];
   logic [W-1:0]   word     [LANES];
   logic [W-1:0]   sync_reg [LANES];
   logic [W-1:0]   dec_reg  [LANES];
   logic [CW-1:0]  bit_cnt;
   logic [1:0]     mode_q;
   logic           sync_valid, dec_valid, mul_valid;
   logic [DW-1:0]  mul_reg;
   logic           last_bit, capture;
   logic [DW-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0]  rd_ptr, wr_ptr;
   logic           pop, full, do_push;
`ifdef DESER_PARITY_EN
   logic [LANES-1:0] par_bad;
`endif

   function automatic logic [W-1:0] decode(input logic [W-1:0] v, input logic [1:0] m);
      logic [W-1:0] r;
      r = v;
      case (m)
         2'b01: for (int i = 0; i < W; i++) r[i] = v[W-1-i];
         2'b10: begin
            r[W-1] = v[W-1];
            for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ v[i];
         end
         2'b11: r = ~v;
         default: r = v;
      endcase
      return r;
   endfunction

   // With parity the shift register already holds the data word when the parity bit arrives
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         sr_nxt[k] = (sr[k] << 1) | W'(dataIn[k]);
`ifdef DESER_PARITY_EN
         word[k]    = sr[k];
         par_bad[k] = ^{sr[k], dataIn[k]};
`else
         word[k]    = sr_nxt[k];
`endif
      end
   end

   assign last_bit = dataInValid && (bit_cnt == CW'(FRAME - 1));
`ifdef DESER_PARITY_EN
   assign capture  = last_bit && !(|par_bad);
`else
   assign capture  = last_bit;
   assign parityErr = 1'b0;
`endif

   always_ff @(posedge fastClk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < LANES; k++) begin
            sr[k]       <= '0;
            sync_reg[k] <= '0;
            dec_reg[k]  <= '0;
         end
         bit_cnt    <= '0;
         mode_q     <= '0;
         sync_valid <= 1'b0;
         dec_valid  <= 1'b0;
         mul_valid  <= 1'b0;
         mul_reg    <= '0;
`ifdef DESER_PARITY_EN
         parityErr  <= 1'b0;
`endif
      end else begin
         if (dataInValid) begin
            for (int k = 0; k < LANES; k++) sr[k] <= sr_nxt[k];
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
         end
`ifdef DESER_PARITY_EN
         parityErr <= last_bit && (|par_bad);
`endif
         sync_valid <= capture;
         if (capture) begin
            for (int k = 0; k < LANES; k++) sync_reg[k] <= word[k];
            mode_q <= mode;
         end
         dec_valid <= sync_valid;
         if (sync_valid)
            for (int k = 0; k < LANES; k++) dec_reg[k] <= decode(sync_reg[k], mode_q);
         mul_valid <= dec_valid;
         if (dec_valid)
            for (int k = 0; k < LANES; k++) mul_reg[k*OW +: OW] <= OW'(dec_reg[k]) * OW'(SCALE);
      end
   end

   assign outValid = (fifoCount != '0);
   assign pop      = outValid && outReady;
   assign full     = (fifoCount == NW'(FIFO_DEPTH));
   assign do_push  = mul_valid && (!full || pop);

   // dataOut is a registered head copy so it can hold the last popped word when empty
   always_ff @(posedge fastClk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifoCount <= '0;
         overflow  <= 1'b0;
         dataOut   <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= mul_reg;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         fifoCount <= fifoCount + NW'(do_push) - NW'(pop);
         if (mul_valid && full && !pop) overflow <= 1'b1;
         if (pop && fifoCount > NW'(1))
            dataOut <= mem[rd_ptr + PW'(1)];
         else if (do_push && (fifoCount == '0 || (pop && fifoCount == NW'(1))))
            dataOut <= mul_reg;
      end
   end
endmodule
